// File: rtl/rptr_empty_level.sv
// Read-side pointer, empty flag and fill-level estimator for an asynchronous FIFO.
// The write Gray pointer is resynchronised into rclk to estimate how many words remain.
module rptr_empty_level #(
  parameter int ADDRSIZE = 8,
  parameter int AE_LEVEL = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic                aempty_n,
  input  logic [ADDRSIZE-1:0] wptr_gray,
  input  logic                runderflow_clr,
  output logic [ADDRSIZE-1:0] rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE-1:0] rlevel,
  output logic                runderflow
);

  localparam logic [ADDRSIZE:0] AE_THRESH = AE_LEVEL[ADDRSIZE:0];

  logic [ADDRSIZE-1:0] rbin;
  logic [ADDRSIZE-1:0] rbnext;
  logic [ADDRSIZE-1:0] rgnext;
  logic                rd_en;
  logic                rempty2;
  logic [ADDRSIZE-1:0] wq1;
  logic [ADDRSIZE-1:0] wq2;
  logic [ADDRSIZE-1:0] wbin_s;
  logic [ADDRSIZE-1:0] lvl_reg;

  // A read only advances the pointer when the FIFO is not empty.
  assign rd_en  = rinc & ~rempty;
  assign rbnext = rbin + {{(ADDRSIZE-1){1'b0}}, rd_en};
  assign rgnext = (rbnext >> 1) ^ rbnext;
  assign raddr  = rbin;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin <= '0;
      rptr <= '0;
    end else begin
      rbin <= rbnext;
      rptr <= rgnext;
    end
  end

  // Empty is set asynchronously by the comparator and released through two rclk flops.
  always_ff @(posedge rclk or posedge rrst or negedge aempty_n) begin
    if (rrst) begin
      {rempty, rempty2} <= 2'b11;
    end else if (!aempty_n) begin
      {rempty, rempty2} <= 2'b11;
    end else begin
      {rempty, rempty2} <= {rempty2, 1'b0};
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
    end
  end

  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < ADDRSIZE; i++) begin
      wbin_s[i] = ^(wq2 >> i);
    end
  end

  // Level is measured against the post-increment pointer so it reflects this cycle's read.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      lvl_reg <= '0;
    end else begin
      lvl_reg <= wbin_s - rbnext;
    end
  end

  assign rlevel        = rempty ? '0 : lvl_reg;
  assign ralmost_empty = rempty | ({1'b0, rlevel} <= AE_THRESH);

  // Set has priority over clear so a coincident underflow is never lost.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      runderflow <= 1'b0;
    end else if (rinc && rempty) begin
      runderflow <= 1'b1;
    end else if (runderflow_clr) begin
      runderflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rptr_empty_level.sv
// Directed bench for rptr_empty_level at ADDRSIZE=4, AE_LEVEL=2.
module tb_rptr_empty_level;

  localparam int AW = 4;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rinc;
  logic          aempty_n;
  logic [AW-1:0] wptr_gray;
  logic          runderflow_clr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] raddr;
  logic          rempty;
  logic          ralmost_empty;
  logic [AW-1:0] rlevel;
  logic          runderflow;

  int n_checks = 0;
  int n_fail   = 0;

  rptr_empty_level #(.ADDRSIZE(AW), .AE_LEVEL(2)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rinc          (rinc),
    .aempty_n      (aempty_n),
    .wptr_gray     (wptr_gray),
    .runderflow_clr(runderflow_clr),
    .rptr          (rptr),
    .raddr         (raddr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it; inputs change here too.
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rptr"},   32'(rptr), 0);
    check_val({tag, "_raddr"},  32'(raddr), 0);
    check_val({tag, "_rempty"}, 32'(rempty), 1);
    check_val({tag, "_ralmost"}, 32'(ralmost_empty), 1);
    check_val({tag, "_rlevel"}, 32'(rlevel), 0);
    check_val({tag, "_runder"}, 32'(runderflow), 0);
  endtask

  logic [AW-1:0] exp_raddr [3] = '{4'd1, 4'd2, 4'd3};
  logic [AW-1:0] exp_rptr  [3] = '{4'b0001, 4'b0011, 4'b0010};
  logic [AW-1:0] exp_lvl   [3] = '{4'd4, 4'd3, 4'd2};
  logic          exp_ae    [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    rrst = 1'b1;
    rinc = 1'b0;
    aempty_n = 1'b0;
    wptr_gray = '0;
    runderflow_clr = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      tick();
      rinc           = 1'($urandom_range(0, 1));
      aempty_n       = 1'($urandom_range(0, 1));
      wptr_gray      = 4'($urandom_range(0, 15));
      runderflow_clr = 1'($urandom_range(0, 1));
    end
    tick();
    check_reset_outputs("reset");

    rinc = 1'b0; aempty_n = 1'b0; wptr_gray = '0; runderflow_clr = 1'b0;
    tick();
    rrst = 1'b0;
    tick();
    tick();

    // Fill: Gray 0111 = 5 words.
    wptr_gray = 4'b0111;
    aempty_n  = 1'b1;
    tick();
    check_val("fill_e1_rempty", 32'(rempty), 1);
    tick();
    check_val("fill_e2_rempty", 32'(rempty), 0);
    tick();
    check_val("fill_e3_rlevel", 32'(rlevel), 5);
    check_val("fill_e3_ralmost", 32'(ralmost_empty), 0);

    // Three reads.
    rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("read%0d_raddr", i), 32'(raddr), 32'(exp_raddr[i]));
      check_val($sformatf("read%0d_rptr", i),  32'(rptr),  32'(exp_rptr[i]));
      check_val($sformatf("read%0d_rlevel", i), 32'(rlevel), 32'(exp_lvl[i]));
      check_val($sformatf("read%0d_ralmost", i), 32'(ralmost_empty), 32'(exp_ae[i]));
    end

    // Keep reading up to rbin=15, then wrap.
    for (int i = 0; i < 12; i++) tick();
    check_val("prewrap_raddr", 32'(raddr), 15);
    check_val("prewrap_rptr",  32'(rptr), 32'(4'b1000));
    tick();
    check_val("wrap_raddr", 32'(raddr), 0);
    check_val("wrap_rptr",  32'(rptr), 0);
    rinc = 1'b0;
    tick();
    check_val("wrap_rlevel", 32'(rlevel), 5);

    // Underflow: empty asserts between edges without a clock.
    #2;
    aempty_n = 1'b0;
    #1;
    check_val("aempty_async_rempty", 32'(rempty), 1);
    check_val("aempty_async_rlevel", 32'(rlevel), 0);
    check_val("aempty_async_ralmost", 32'(ralmost_empty), 1);
    rinc = 1'b1;
    tick();
    check_val("under_raddr_hold", 32'(raddr), 0);
    check_val("under_rptr_hold",  32'(rptr), 0);
    check_val("under_set", 32'(runderflow), 1);
    runderflow_clr = 1'b1;
    tick();
    check_val("under_set_wins", 32'(runderflow), 1);
    check_val("under_raddr_hold2", 32'(raddr), 0);
    rinc = 1'b0;
    tick();
    check_val("under_clear", 32'(runderflow), 0);
    runderflow_clr = 1'b0;
    rinc = 1'b1;
    tick();
    check_val("under_reset_again", 32'(runderflow), 1);
    rinc = 1'b0;

    // Refill and read up to raddr=7.
    aempty_n = 1'b1;
    tick();
    tick();
    check_val("refill_rempty", 32'(rempty), 0);
    rinc = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check_val("midread_raddr", 32'(raddr), 7);
    check_val("midread_rptr",  32'(rptr), 32'(4'b0100));
    check_val("midread_runder", 32'(runderflow), 1);

    // Asynchronous reset between edges.
    #2;
    rrst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    rinc = 1'b0;
    tick();
    rrst = 1'b0;

    // Normal operation resumes after release.
    tick();
    check_val("resume_e1_rempty", 32'(rempty), 1);
    tick();
    check_val("resume_e2_rempty", 32'(rempty), 0);
    tick();
    check_val("resume_e3_rlevel", 32'(rlevel), 5);
    check_val("resume_raddr", 32'(raddr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
